// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: fetch state encoding, PC source selects
// and the machine word width.
package lc3_pkg;

   localparam int WORD_W = 16;

   localparam logic [1:0] SEL_PC_INC = 2'b00;
   localparam logic [1:0] SEL_PC_EAB = 2'b01;
   localparam logic [1:0] SEL_PC_BUS = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LOAD  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_FAULT = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_unit_if.sv
// Signal bundle between the fetch unit (master) and its PC, memory and
// decode neighbours (slave).
interface lc3_fetch_unit_if
   import lc3_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // Memory: mem_en stays high until the first cycle mem_rdy=1, data is taken
   // that same cycle. Decode: ir_out transfers on a cycle with ir_valid=1 and
   // ir_ready=1; ir_valid and ir_out stay stable until then.
   logic              run;
   logic [ADDR_W-1:0] pc_in;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_en;
   logic              mem_rdy;
   logic [DATA_W-1:0] mem_data;
   logic              ld_pc;
   logic [1:0]        sel_pc;
   logic [DATA_W-1:0] ir_out;
   logic              ir_valid;
   logic              ir_ready;
   logic              busy;
   logic              fault;
   fetch_state_e      dbg_state;

   modport master (
      input  run, pc_in, mem_rdy, mem_data, ir_ready,
      output mem_addr, mem_en, ld_pc, sel_pc, ir_out, ir_valid, busy, fault,
             dbg_state
   );

   modport slave (
      output run, pc_in, mem_rdy, mem_data, ir_ready,
      input  mem_addr, mem_en, ld_pc, sel_pc, ir_out, ir_valid, busy, fault,
             dbg_state
   );

endinterface

// File: rtl/lc3_wait_timer.sv
// Up-counter with synchronous clear, parallel load and count enable; last_o
// flags that the count equals last_val_i.
module lc3_wait_timer
   import lc3_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   input  logic         en_i,
   input  logic [W-1:0] last_val_i,
   output logic         last_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (ld_i)  cnt_d = ld_val_i;
      else if (en_i)  cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign last_o = (cnt_q == last_val_i);

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch sequencer: PC -> MAR, wait on R, MDR -> IR, PC
// increment strobe, then hand the instruction to decode.
module lc3_fetch_unit
   import lc3_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   lc3_fetch_unit_if.master bus
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The terminal flag marks the last tolerated idle WAIT cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_en_q, mem_en_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              tmr_clr, tmr_en, tmr_last, timeout_hit;

   lc3_wait_timer #(.W(CNT_W)) u_wait_timer (
      .clk_i      (clk),
      .rst_i      (reset),
      .clr_i      (tmr_clr),
      .ld_i       (1'b0),
      .ld_val_i   ({CNT_W{1'b0}}),
      .en_i       (tmr_en),
      .last_val_i (CNT_LAST),
      .last_o     (tmr_last)
   );

   assign timeout_hit = (TIMEOUT != 0) && tmr_last;

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_en_d   = mem_en_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.run) state_d = ST_ADDR;
         ST_ADDR: begin
            mem_addr_d = bus.pc_in;
            mem_en_d   = 1'b1;
            tmr_clr    = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // A ready on the final allowed cycle still captures.
            if (bus.mem_rdy) begin
               ir_d     = bus.mem_data;
               mem_en_d = 1'b0;
               state_d  = ST_LOAD;
            end else if (timeout_hit) begin
               mem_en_d = 1'b0;
               state_d  = ST_FAULT;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_LOAD: begin
            ir_valid_d = 1'b1;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = bus.run ? ST_ADDR : ST_IDLE;
            end
         end
         ST_FAULT: begin
            mem_en_d   = 1'b0;
            ir_valid_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mem_addr_q <= '0;
         mem_en_q   <= 1'b0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_en_q   <= mem_en_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.ir_out    = ir_q;
   assign bus.ir_valid  = ir_valid_q;
   assign bus.ld_pc     = (state_q == ST_LOAD);
   assign bus.sel_pc    = SEL_PC_INC;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.fault     = (state_q == ST_FAULT);
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Bench for lc3_fetch_unit: default-timeout instance for fetch scenarios and
// a TIMEOUT=4 instance for the fault and ready-on-last-cycle cases.
module tb_lc3_fetch_unit;
   import lc3_pkg::*;

   logic clk;
   logic reset;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   ld_cnt = 0;
   int   ld_cnt_to = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_word;

   lc3_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();
   lc3_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus_to ();

   lc3_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(255)) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   lc3_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) u_dut_to (
      .clk(clk), .reset(reset), .bus(bus_to)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard: pop on every decode accept, count PC load strobes
   always @(negedge clk) begin
      if (!reset && bus.ir_valid && bus.ir_ready) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_underflow got=%h exp=none", bus.ir_out);
         end else begin
            exp_word = exp_q.pop_front();
            if (bus.ir_out !== exp_word)
               $display("FAIL sb_ir_out got=%h exp=%h", bus.ir_out, exp_word);
            else pass_cnt++;
         end
      end
      if (!reset && bus.ld_pc) begin
         ld_cnt++;
         total_cnt++;
         if (bus.sel_pc !== SEL_PC_INC)
            $display("FAIL sel_pc_on_ld got=%b exp=%b", bus.sel_pc, SEL_PC_INC);
         else pass_cnt++;
      end
      if (!reset && bus_to.ld_pc) ld_cnt_to++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      total_cnt++; if (bus.mem_addr !== 16'h0) $display("FAIL rst_mem_addr got=%h exp=0000", bus.mem_addr); else pass_cnt++;
      total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); else pass_cnt++;
      total_cnt++; if (bus.ld_pc !== 1'b0) $display("FAIL rst_ld_pc got=%b exp=0", bus.ld_pc); else pass_cnt++;
      total_cnt++; if (bus.sel_pc !== 2'b00) $display("FAIL rst_sel_pc got=%b exp=00", bus.sel_pc); else pass_cnt++;
      total_cnt++; if (bus.ir_out !== 16'h0) $display("FAIL rst_ir_out got=%h exp=0000", bus.ir_out); else pass_cnt++;
      total_cnt++; if (bus.ir_valid !== 1'b0) $display("FAIL rst_ir_valid got=%b exp=0", bus.ir_valid); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.fault !== 1'b0) $display("FAIL rst_fault got=%b exp=0", bus.fault); else pass_cnt++;
      total_cnt++; if (bus.dbg_state !== ST_IDLE) $display("FAIL rst_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int ld0 = ld_cnt;
      bus.pc_in = 16'h3000;
      bus.run = 1'b1;
      tick();  // ADDR
      total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL basic_addr_mem_en got=%b exp=0", bus.mem_en); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", bus.busy); else pass_cnt++;
      tick();  // WAIT
      total_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL basic_mem_en got=%b exp=1", bus.mem_en); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== 16'h3000) $display("FAIL basic_mem_addr got=%h exp=3000", bus.mem_addr); else pass_cnt++;
      bus.mem_rdy = 1'b1;
      bus.mem_data = 16'h1021;
      exp_q.push_back(16'h1021);
      bus.run = 1'b0;
      tick();  // LOAD
      bus.mem_rdy = 1'b0;
      total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL basic_load_mem_en got=%b exp=0", bus.mem_en); else pass_cnt++;
      total_cnt++; if (bus.ld_pc !== 1'b1) $display("FAIL basic_ld_pc got=%b exp=1", bus.ld_pc); else pass_cnt++;
      total_cnt++; if (bus.ir_valid !== 1'b0) $display("FAIL basic_load_ir_valid got=%b exp=0", bus.ir_valid); else pass_cnt++;
      tick();  // HOLD
      total_cnt++; if (bus.ir_valid !== 1'b1) $display("FAIL basic_ir_valid got=%b exp=1", bus.ir_valid); else pass_cnt++;
      total_cnt++; if (bus.ir_out !== 16'h1021) $display("FAIL basic_ir_out got=%h exp=1021", bus.ir_out); else pass_cnt++;
      total_cnt++; if (bus.ld_pc !== 1'b0) $display("FAIL basic_hold_ld_pc got=%b exp=0", bus.ld_pc); else pass_cnt++;
      bus.ir_ready = 1'b1;
      tick();  // IDLE
      bus.ir_ready = 1'b0;
      total_cnt++; if (bus.ir_valid !== 1'b0) $display("FAIL basic_clear_valid got=%b exp=0", bus.ir_valid); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL basic_idle_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (ld_cnt - ld0 !== 1) $display("FAIL basic_ld_count got=%0d exp=1", ld_cnt - ld0); else pass_cnt++;
   endtask

   task automatic test_wait_delay();
      logic [15:0] word = 16'($urandom_range(0, 65535));
      int ld0 = ld_cnt;
      bus.pc_in = 16'h4000;
      bus.run = 1'b1;
      tick();  // ADDR
      bus.run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();  // WAIT cycle i+1
         bus.pc_in = 16'($urandom_range(0, 65535));
         total_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL delay_mem_en cyc=%0d got=%b exp=1", i, bus.mem_en); else pass_cnt++;
         total_cnt++; if (bus.mem_addr !== 16'h4000) $display("FAIL delay_mem_addr cyc=%0d got=%h exp=4000", i, bus.mem_addr); else pass_cnt++;
         total_cnt++; if (bus.ld_pc !== 1'b0) $display("FAIL delay_ld_pc cyc=%0d got=%b exp=0", i, bus.ld_pc); else pass_cnt++;
      end
      bus.mem_rdy = 1'b1;
      bus.mem_data = word;
      exp_q.push_back(word);
      tick();  // LOAD
      bus.mem_rdy = 1'b0;
      total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL delay_load_mem_en got=%b exp=0", bus.mem_en); else pass_cnt++;
      total_cnt++; if (bus.ld_pc !== 1'b1) $display("FAIL delay_load_ld_pc got=%b exp=1", bus.ld_pc); else pass_cnt++;
      tick();  // HOLD
      total_cnt++; if (bus.ir_out !== word) $display("FAIL delay_ir_out got=%h exp=%h", bus.ir_out, word); else pass_cnt++;
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      total_cnt++; if (ld_cnt - ld0 !== 1) $display("FAIL delay_ld_count got=%0d exp=1", ld_cnt - ld0); else pass_cnt++;
   endtask

   task automatic test_hold_stall();
      logic [15:0] w0 = 16'($urandom_range(0, 65535));
      logic [15:0] w1 = 16'($urandom_range(0, 65535));
      bus.pc_in = 16'h3000;
      bus.run = 1'b1;
      tick();  // ADDR
      tick();  // WAIT
      bus.mem_rdy = 1'b1;
      bus.mem_data = w0;
      exp_q.push_back(w0);
      tick();  // LOAD: PC register advances on this edge
      bus.mem_rdy = 1'b0;
      bus.pc_in = 16'h3001;
      tick();  // HOLD
      for (int i = 0; i < 10; i++) begin
         tick();
         total_cnt++; if (bus.ir_valid !== 1'b1) $display("FAIL stall_ir_valid cyc=%0d got=%b exp=1", i, bus.ir_valid); else pass_cnt++;
         total_cnt++; if (bus.ir_out !== w0) $display("FAIL stall_ir_out cyc=%0d got=%h exp=%h", i, bus.ir_out, w0); else pass_cnt++;
         total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL stall_mem_en cyc=%0d got=%b exp=0", i, bus.mem_en); else pass_cnt++;
         total_cnt++; if (bus.dbg_state !== ST_HOLD) $display("FAIL stall_state cyc=%0d got=%0d exp=%0d", i, bus.dbg_state, ST_HOLD); else pass_cnt++;
      end
      bus.ir_ready = 1'b1;
      tick();  // ADDR again
      bus.ir_ready = 1'b0;
      total_cnt++; if (bus.ir_valid !== 1'b0) $display("FAIL stall_accept_valid got=%b exp=0", bus.ir_valid); else pass_cnt++;
      total_cnt++; if (bus.dbg_state !== ST_ADDR) $display("FAIL stall_restart_state got=%0d exp=%0d", bus.dbg_state, ST_ADDR); else pass_cnt++;
      tick();  // WAIT
      total_cnt++; if (bus.mem_addr !== 16'h3001) $display("FAIL stall_next_addr got=%h exp=3001", bus.mem_addr); else pass_cnt++;
      total_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL stall_next_mem_en got=%b exp=1", bus.mem_en); else pass_cnt++;
      bus.mem_rdy = 1'b1;
      bus.mem_data = w1;
      exp_q.push_back(w1);
      bus.run = 1'b0;
      tick();  // LOAD
      bus.mem_rdy = 1'b0;
      tick();  // HOLD
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL stall_end_busy got=%b exp=0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_run_drop();
      logic [15:0] word = 16'($urandom_range(0, 65535));
      int ld0 = ld_cnt;
      bus.pc_in = 16'h5100;
      bus.run = 1'b1;
      tick();  // ADDR
      tick();  // WAIT
      bus.run = 1'b0;
      repeat (2) begin
         tick();
         total_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL drop_mem_en got=%b exp=1", bus.mem_en); else pass_cnt++;
      end
      bus.mem_rdy = 1'b1;
      bus.mem_data = word;
      exp_q.push_back(word);
      tick();  // LOAD
      bus.mem_rdy = 1'b0;
      tick();  // HOLD
      total_cnt++; if (bus.ir_valid !== 1'b1) $display("FAIL drop_ir_valid got=%b exp=1", bus.ir_valid); else pass_cnt++;
      bus.ir_ready = 1'b1;
      tick();  // IDLE
      bus.ir_ready = 1'b0;
      bus.mem_rdy = 1'b1;
      bus.mem_data = ~word;
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++; if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) $display("FAIL drop_idle cyc=%0d got=%b%b exp=00", i, bus.mem_en, bus.busy); else pass_cnt++;
         total_cnt++; if (bus.ir_out !== word) $display("FAIL drop_ir_hold cyc=%0d got=%h exp=%h", i, bus.ir_out, word); else pass_cnt++;
      end
      bus.mem_rdy = 1'b0;
      total_cnt++; if (ld_cnt - ld0 !== 1) $display("FAIL drop_ld_count got=%0d exp=1", ld_cnt - ld0); else pass_cnt++;
   endtask

   task automatic test_reset_in_wait();
      logic [15:0] word = 16'($urandom_range(0, 65535));
      int ld0 = ld_cnt;
      bus.pc_in = 16'h6000;
      bus.run = 1'b1;
      tick();  // ADDR
      tick();  // WAIT
      tick();  // WAIT
      reset = 1'b1;
      bus.mem_rdy = 1'b1;
      bus.mem_data = 16'hDEAD;
      tick();
      total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL rstw_mem_en got=%b exp=0", bus.mem_en); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== 16'h0) $display("FAIL rstw_mem_addr got=%h exp=0000", bus.mem_addr); else pass_cnt++;
      total_cnt++; if (bus.ir_out !== 16'h0) $display("FAIL rstw_ir_out got=%h exp=0000", bus.ir_out); else pass_cnt++;
      total_cnt++; if (bus.ir_valid !== 1'b0 || bus.ld_pc !== 1'b0) $display("FAIL rstw_valid_ld got=%b%b exp=00", bus.ir_valid, bus.ld_pc); else pass_cnt++;
      total_cnt++; if (bus.dbg_state !== ST_IDLE) $display("FAIL rstw_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); else pass_cnt++;
      reset = 1'b0;
      bus.mem_rdy = 1'b0;
      tick();  // ADDR
      total_cnt++; if (bus.dbg_state !== ST_ADDR) $display("FAIL rstw_restart got=%0d exp=%0d", bus.dbg_state, ST_ADDR); else pass_cnt++;
      tick();  // WAIT
      total_cnt++; if (bus.mem_addr !== 16'h6000) $display("FAIL rstw_addr got=%h exp=6000", bus.mem_addr); else pass_cnt++;
      bus.mem_rdy = 1'b1;
      bus.mem_data = word;
      exp_q.push_back(word);
      bus.run = 1'b0;
      tick();  // LOAD
      bus.mem_rdy = 1'b0;
      tick();  // HOLD
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      total_cnt++; if (ld_cnt - ld0 !== 1) $display("FAIL rstw_ld_count got=%0d exp=1", ld_cnt - ld0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] pc = 16'h5000;
      logic [15:0] word;
      bus.pc_in = pc;
      bus.ir_ready = 1'b1;
      bus.run = 1'b1;
      tick();  // IDLE -> ADDR
      for (int n = 0; n < 4; n++) begin
         total_cnt++; if (bus.dbg_state !== ST_ADDR) $display("FAIL b2b_addr n=%0d got=%0d exp=%0d", n, bus.dbg_state, ST_ADDR); else pass_cnt++;
         tick();  // WAIT
         total_cnt++; if (bus.mem_addr !== pc || bus.mem_en !== 1'b1) $display("FAIL b2b_mem n=%0d got=%h/%b exp=%h/1", n, bus.mem_addr, bus.mem_en, pc); else pass_cnt++;
         word = 16'($urandom_range(0, 65535));
         bus.mem_rdy = 1'b1;
         bus.mem_data = word;
         exp_q.push_back(word);
         tick();  // LOAD
         bus.mem_rdy = 1'b0;
         total_cnt++; if (bus.ld_pc !== 1'b1) $display("FAIL b2b_ld_pc n=%0d got=%b exp=1", n, bus.ld_pc); else pass_cnt++;
         pc = pc + 16'h1;
         bus.pc_in = pc;
         if (n == 3) bus.run = 1'b0;
         tick();  // HOLD, accepted this cycle
         total_cnt++; if (bus.ir_valid !== 1'b1) $display("FAIL b2b_ir_valid n=%0d got=%b exp=1", n, bus.ir_valid); else pass_cnt++;
         tick();  // next ADDR or IDLE
      end
      bus.ir_ready = 1'b0;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL b2b_end_busy got=%b exp=0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_timeout();
      logic [15:0] word = 16'($urandom_range(0, 65535));
      bus_to.run = 1'b1;
      tick();  // ADDR
      for (int i = 0; i < 4; i++) begin
         tick();  // WAIT cycles 1..4
         total_cnt++; if (bus_to.mem_en !== 1'b1 || bus_to.fault !== 1'b0) $display("FAIL to_wait cyc=%0d got=%b%b exp=10", i, bus_to.mem_en, bus_to.fault); else pass_cnt++;
      end
      tick();
      total_cnt++; if (bus_to.fault !== 1'b1) $display("FAIL to_fault got=%b exp=1", bus_to.fault); else pass_cnt++;
      total_cnt++; if (bus_to.mem_en !== 1'b0 || bus_to.ir_valid !== 1'b0) $display("FAIL to_fault_outs got=%b%b exp=00", bus_to.mem_en, bus_to.ir_valid); else pass_cnt++;
      bus_to.run = 1'b0;
      bus_to.mem_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++; if (bus_to.fault !== 1'b1 || bus_to.mem_en !== 1'b0) $display("FAIL to_sticky cyc=%0d got=%b%b exp=10", i, bus_to.fault, bus_to.mem_en); else pass_cnt++;
      end
      bus_to.mem_rdy = 1'b0;
      total_cnt++; if (ld_cnt_to !== 0) $display("FAIL to_ld_count got=%0d exp=0", ld_cnt_to); else pass_cnt++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total_cnt++; if (bus_to.fault !== 1'b0 || bus_to.busy !== 1'b0) $display("FAIL to_reset got=%b%b exp=00", bus_to.fault, bus_to.busy); else pass_cnt++;
      // ready arriving on the last allowed WAIT cycle must win
      bus_to.run = 1'b1;
      tick();  // ADDR
      repeat (4) tick();  // WAIT cycles 1..4
      bus_to.mem_rdy = 1'b1;
      bus_to.mem_data = word;
      bus_to.run = 1'b0;
      tick();  // LOAD
      bus_to.mem_rdy = 1'b0;
      total_cnt++; if (bus_to.fault !== 1'b0 || bus_to.ld_pc !== 1'b1) $display("FAIL to_edge_load got=%b%b exp=01", bus_to.fault, bus_to.ld_pc); else pass_cnt++;
      tick();  // HOLD
      total_cnt++; if (bus_to.ir_out !== word || bus_to.ir_valid !== 1'b1) $display("FAIL to_edge_ir got=%h/%b exp=%h/1", bus_to.ir_out, bus_to.ir_valid, word); else pass_cnt++;
      bus_to.ir_ready = 1'b1;
      tick();
      bus_to.ir_ready = 1'b0;
      total_cnt++; if (bus_to.busy !== 1'b0 || ld_cnt_to !== 1) $display("FAIL to_edge_end got=%b/%0d exp=0/1", bus_to.busy, ld_cnt_to); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      bus.run = 1'b0;      bus.pc_in = 16'h0;    bus.mem_rdy = 1'b0;
      bus.mem_data = 16'h0; bus.ir_ready = 1'b0;
      bus_to.run = 1'b0;   bus_to.pc_in = 16'h0200; bus_to.mem_rdy = 1'b0;
      bus_to.mem_data = 16'h0; bus_to.ir_ready = 1'b0;
      test_reset();
      test_basic();
      test_wait_delay();
      test_hold_stall();
      test_run_drop();
      test_reset_in_wait();
      test_back_to_back();
      test_timeout();
      repeat (2) tick();
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
